// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: register-file write sequencing, Z/V flags, retired count
module alu_writeback #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           result,
  input  logic                  z_flag,
  input  logic                  v_flag,
  input  logic                  flags_we,
  input  logic                  wide,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rd_hi,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [15:0]           rf_wdata,
  output logic                  z_reg,
  output logic                  v_reg,
  output logic [15:0]           retired
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WR_HI = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [15:0]           rf_wdata_q, rf_wdata_d;
  logic                  z_q, z_d;
  logic                  v_q, v_d;
  logic [15:0]           retired_q, retired_d;
  logic [REG_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [15:0]           hold_data_q, hold_data_d;
  logic                  accept;

  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign z_reg    = z_q;
  assign v_reg    = v_q;
  assign retired  = retired_q;

  // Next state: low half on accept, high half one cycle later unless flushed.
  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    z_d         = z_q;
    v_d         = v_q;
    retired_d   = retired_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = rd;
          rf_wdata_d = result[15:0];
          retired_d  = retired_q + 16'd1;
          if (flags_we) begin
            z_d = z_flag;
            v_d = v_flag;
          end
          if (wide) begin
            hold_addr_d = rd_hi;
            hold_data_d = result[31:16];
            state_d     = WR_HI;
          end
        end
      end
      WR_HI: begin
        state_d = IDLE;
        if (!flush) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = hold_addr_q;
          rf_wdata_d = hold_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any pending high-half write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      retired_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      z_q         <= z_d;
      v_q         <= v_d;
      retired_q   <= retired_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule
